booth_pp_accumulator: RTL and testbench

BOOTH_PP_ACCUMULATOR -- requirements
Module: booth_pp_accumulator

---
 rtl/booth_pp_accumulator_pkg.sv | 26 ++
 rtl/booth_pp_select.sv | 39 +++
 rtl/booth_pp_accumulator.sv | 137 +++++++++++++
 tb/tb_booth_pp_accumulator.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/booth_pp_accumulator_pkg.sv
// Shared constants for the Booth partial-product accumulator: operand width,
// FSM encodings, NUM_PP derivation. Optional macro: BOOTH_ACC_TWO_PER_CYCLE_EN.
`ifndef WIDTH_DATA
`define WIDTH_DATA 16
`endif

package booth_pp_accumulator_pkg;

    localparam int unsigned WIDTH_DATA_DEFAULT = `WIDTH_DATA;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

`ifdef BOOTH_ACC_TWO_PER_CYCLE_EN
    localparam int unsigned PP_PER_CYCLE = 2;
`else
    localparam int unsigned PP_PER_CYCLE = 1;
`endif

    // Radix-4 Booth yields one partial product per two multiplier bits
    function automatic int unsigned num_pp_of(input int unsigned width_data);
        return width_data / 2;
    endfunction

endpackage

// File: rtl/booth_pp_select.sv
// Partial-product mux: picks pp_reg[idx] (and pp_reg[idx+1] when
// BOOTH_ACC_TWO_PER_CYCLE_EN is defined) out of the packed register.
module booth_pp_select
    import booth_pp_accumulator_pkg::*;
#(
    parameter int unsigned PP_W   = 32,
    parameter int unsigned NUM_PP = 8,
    parameter int unsigned IDX_W  = 4
) (
    input  logic [PP_W*NUM_PP-1:0] pp_reg,
    input  logic [IDX_W-1:0]       idx,
`ifdef BOOTH_ACC_TWO_PER_CYCLE_EN
    output logic [PP_W-1:0]        pp_b_c,
`endif
    output logic [PP_W-1:0]        pp_a_c
);

    // Out-of-range idx (after the last add) selects zero
    always_comb begin
        pp_a_c = '0;
        for (int k = 0; k < int'(NUM_PP); k++) begin
            if (idx == IDX_W'(k)) begin
                pp_a_c = pp_reg[k*PP_W +: PP_W];
            end
        end
    end

`ifdef BOOTH_ACC_TWO_PER_CYCLE_EN
    always_comb begin
        pp_b_c = '0;
        for (int k = 0; k < int'(NUM_PP) - 1; k++) begin
            if (idx == IDX_W'(k)) begin
                pp_b_c = pp_reg[(k+1)*PP_W +: PP_W];
            end
        end
    end
`endif

endmodule

// File: rtl/booth_pp_accumulator.sv
// Sums a captured bus of Booth partial products into a signed product over
// several cycles. Optional macro: BOOTH_ACC_TWO_PER_CYCLE_EN (two adds/cycle).
module booth_pp_accumulator
    import booth_pp_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH_DATA = `WIDTH_DATA,
    parameter int unsigned NUM_PP     = num_pp_of(WIDTH_DATA)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH_DATA*2*NUM_PP-1:0] pp,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [2*WIDTH_DATA-1:0]        product,
    output logic                           busy
);

    localparam int unsigned PP_W     = 2 * WIDTH_DATA;
    localparam int unsigned BUS_W    = PP_W * NUM_PP;
    localparam int unsigned IDX_W    = $clog2(NUM_PP + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PP - PP_PER_CYCLE);
    localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(PP_PER_CYCLE);

`ifdef BOOTH_ACC_TWO_PER_CYCLE_EN
    if (NUM_PP % 2 != 0) begin : g_num_pp_odd
        $error("NUM_PP must be even for two partial products per cycle");
    end
`endif

    logic [1:0]       state, state_nxt;
    logic [PP_W-1:0]  acc, acc_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [BUS_W-1:0] pp_reg, pp_reg_nxt;
    logic             in_ready_nxt, out_valid_nxt, busy_nxt;
    logic [PP_W-1:0]  pp_a_c;
    logic [PP_W-1:0]  add_c;

`ifdef BOOTH_ACC_TWO_PER_CYCLE_EN
    logic [PP_W-1:0]  pp_b_c;

    booth_pp_select #(
        .PP_W   (PP_W),
        .NUM_PP (NUM_PP),
        .IDX_W  (IDX_W)
    ) u_select (
        .pp_reg (pp_reg),
        .idx    (idx),
        .pp_b_c (pp_b_c),
        .pp_a_c (pp_a_c)
    );

    assign add_c = pp_a_c + pp_b_c;
`else
    booth_pp_select #(
        .PP_W   (PP_W),
        .NUM_PP (NUM_PP),
        .IDX_W  (IDX_W)
    ) u_select (
        .pp_reg (pp_reg),
        .idx    (idx),
        .pp_a_c (pp_a_c)
    );

    assign add_c = pp_a_c;
`endif

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            idx       <= '0;
            pp_reg    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            idx       <= idx_nxt;
            pp_reg    <= pp_reg_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state and next-output logic; sums wrap modulo 2^PP_W
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        idx_nxt       = idx;
        pp_reg_nxt    = pp_reg;
        in_ready_nxt  = in_ready;
        out_valid_nxt = out_valid;
        busy_nxt      = busy;
        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    pp_reg_nxt   = pp;
                    acc_nxt      = '0;
                    idx_nxt      = '0;
                    state_nxt    = ST_ACC;
                    in_ready_nxt = 1'b0;
                    busy_nxt     = 1'b1;
                end
            end
            ST_ACC: begin
                acc_nxt = acc + add_c;
                idx_nxt = idx + IDX_STEP;
                if (idx == LAST_IDX) begin
                    state_nxt     = ST_DONE;
                    out_valid_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt     = ST_IDLE;
                    out_valid_nxt = 1'b0;
                    busy_nxt      = 1'b0;
                    in_ready_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                out_valid_nxt = 1'b0;
                busy_nxt      = 1'b0;
                in_ready_nxt  = 1'b1;
            end
        endcase
    end

    assign product = acc;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed bench for booth_pp_accumulator at WIDTH_DATA=16; honours
// BOOTH_ACC_TWO_PER_CYCLE_EN for the expected latency.
module tb_booth_pp_accumulator;

`ifdef BOOTH_ACC_TWO_PER_CYCLE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 8;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] pp;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  product;
    logic         busy;

    int tests = 0;
    int fails = 0;

    booth_pp_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp        (pp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] weight;
        logic [15:0] feature;
        logic [31:0] product;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Radix-4 Booth partial products of weight*feature, sign-extended and shifted
    function automatic logic [255:0] booth_pps(input logic [15:0] w, input logic [15:0] f);
        logic [255:0]       bus;
        logic [16:0]        y;
        logic [2:0]         trip;
        logic signed [31:0] fe;
        logic signed [31:0] term;
        int                 d;
        bus = '0;
        y   = {w, 1'b0};
        fe  = 32'(signed'(f));
        for (int k = 0; k < 8; k++) begin
            trip = y[2*k +: 3];
            case (trip)
                3'b001, 3'b010: d = 1;
                3'b011:         d = 2;
                3'b100:         d = -2;
                3'b101, 3'b110: d = -1;
                default:        d = 0;
            endcase
            term = 32'(fe * d);
            bus[k*32 +: 32] = term <<< (2*k);
        end
        return bus;
    endfunction

    // Accept one bus, check latency and product; optionally complete the handshake
    task automatic run_op(input logic [255:0] bus, input logic [31:0] exp,
                          input string name, input bit complete);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " in_ready before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        pp       = bus;
        @(posedge clk); #1;
        in_valid = 1'b0;
        pp       = {8{32'($urandom())}};
        check({name, " busy after accept"}, 32'(busy), 32'd1);
        check({name, " in_ready after accept"}, 32'(in_ready), 32'd0);
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) break;
        end
        check({name, " latency"}, 32'(n), 32'(LAT));
        check({name, " product"}, product, exp);
        if (complete) begin
            @(posedge clk); #1;
            check({name, " out_valid after handshake"}, 32'(out_valid), 32'd0);
            check({name, " in_ready after handshake"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        int ov_seen;
        logic [255:0] bus;

        vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[1] = '{16'hFFFF, 16'h0007, 32'hFFFFFFF9};
        vecs[2] = '{16'h8000, 16'h8000, 32'h40000000};
        vecs[3] = '{16'h0002, 16'hFFFD, 32'hFFFFFFFA};
        vecs[4] = '{16'h1234, 16'h0010, 32'h00012340};
        vecs[5] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 32'h00000001};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pp        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset product", product, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_op(booth_pps(vecs[i].weight, vecs[i].feature), vecs[i].product,
                   $sformatf("vec%0d", i), 1'b1);
        end

        // Raw buses exercising wrap-around of the accumulator
        bus = {8{32'h80000000}};
        run_op(bus, 32'h00000000, "wrap_min", 1'b1);
        bus = {8{32'h7FFFFFFF}};
        run_op(bus, 32'hFFFFFFF8, "wrap_max", 1'b1);

        // Backpressure in DONE; a new in_valid meanwhile must be ignored
        out_ready = 1'b0;
        run_op(booth_pps(16'h0003, 16'h0005), 32'h0000000F, "hold", 1'b0);
        in_valid = 1'b1;
        pp       = booth_pps(16'h0009, 16'h0009);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d product", c), product, 32'h0000000F);
            check($sformatf("hold%0d out_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("hold%0d in_ready", c), 32'(in_ready), 32'd0);
            check($sformatf("hold%0d busy", c), 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("hold release out_valid", 32'(out_valid), 32'd0);
        check("hold release in_ready", 32'(in_ready), 32'd1);
        check("hold release busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("hold no queued op", 32'(busy), 32'd0);

        // Reset during accumulation discards the operation
        in_valid = 1'b1;
        pp       = booth_pps(16'h0005, 16'h0005);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_acc in_ready", 32'(in_ready), 32'd1);
        check("rst_acc busy", 32'(busy), 32'd0);
        check("rst_acc out_valid", 32'(out_valid), 32'd0);
        check("rst_acc product", product, 32'd0);
        ov_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid) ov_seen++;
        end
        check("rst_acc no out_valid", 32'(ov_seen), 32'd0);
        run_op(booth_pps(16'h0002, 16'hFFFD), 32'hFFFFFFFA, "after_rst", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
